// File: rtl/ber_checker.sv
// BER checker: decimates x4 filter output, slices to bits, searches the PRBS reference delay,
// then counts bits/errors while locked. Optional BER_LOCK_LOSS_EN adds windowed lock-loss detection.
module ber_checker #(
  parameter int unsigned NB_DATA  = 8,
  parameter int unsigned PRBS_LEN = 511,
  parameter int unsigned NB_DELAY = 9,
  parameter int unsigned N_WIN    = 128,
  parameter int unsigned NB_CNT   = 64,
  parameter int unsigned LOSS_THR = 16
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [1:0]          i_phase,
  input  logic                i_ref_valid,
  input  logic                i_ref_bit,
  input  logic                i_restart,
  output logic                o_bit,
  output logic                o_bit_valid,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  // Window counters are sized to hold both the window length and the loss threshold.
  localparam int unsigned WinMax = (N_WIN > LOSS_THR) ? N_WIN : LOSS_THR;
  localparam int unsigned NbWin  = $clog2(WinMax + 1);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [PRBS_LEN-1:0]   ref_q, ref_d;
  logic [NB_DELAY-1:0]   delay_q, delay_d;
  logic [NbWin-1:0]      win_cnt_q, win_cnt_d;
  logic [NbWin-1:0]      win_err_q, win_err_d;
  logic                  bit_q, bit_d;
  logic                  bit_valid_q, bit_valid_d;
  logic [NB_CNT-1:0]     bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]     err_cnt_q, err_cnt_d;

  logic                  step;
  logic                  decision;
  logic                  sliced;
  logic                  mismatch;
  logic                  win_last;
  logic [NbWin-1:0]      win_err_total;
  logic                  unused_data;

  assign unused_data   = ^i_data[NB_DATA-2:0];
  assign step          = i_enable;
  assign decision      = step & i_valid & (phase_q == i_phase);
  assign sliced        = i_data[NB_DATA-1];
  // Compare against pre-edge buffer contents; a push on this edge is not yet visible.
  assign mismatch      = sliced ^ ref_q[delay_q];
  assign win_last      = (win_cnt_q == NbWin'(N_WIN - 1));
  assign win_err_total = win_err_q + NbWin'(mismatch);

  always_comb begin
    phase_d     = phase_q;
    ref_d       = ref_q;
    bit_d       = bit_q;
    bit_valid_d = bit_valid_q;
    if (step) begin
      bit_valid_d = decision;
      if (decision) begin
        bit_d = sliced;
      end
      if (i_valid) begin
        phase_d = phase_q + 2'd1;
      end
      if (i_ref_valid) begin
        ref_d = {ref_q[PRBS_LEN-2:0], i_ref_bit};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (step) begin
      if (i_restart) begin
        state_d   = StSearch;
        delay_d   = '0;
        win_cnt_d = '0;
        win_err_d = '0;
        bit_cnt_d = '0;
        err_cnt_d = '0;
      end else if (decision) begin
        case (state_q)
          StSearch: begin
            if (win_last) begin
              win_cnt_d = '0;
              win_err_d = '0;
              if (win_err_total == '0) begin
                state_d = StLocked;
              end else if (delay_q == NB_DELAY'(PRBS_LEN - 1)) begin
                delay_d = '0;
              end else begin
                delay_d = delay_q + 1'b1;
              end
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
              win_err_d = win_err_total;
            end
          end
          StLocked: begin
            if (bit_cnt_q != '1) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (mismatch && (err_cnt_q != '1)) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
`ifdef BER_LOCK_LOSS_EN
            // Counters are kept on lock loss so the BER so far stays readable.
            if (win_last) begin
              win_cnt_d = '0;
              win_err_d = '0;
              if (32'(win_err_total) >= LOSS_THR) begin
                state_d = StSearch;
                delay_d = '0;
              end
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
              win_err_d = win_err_total;
            end
`endif
          end
          default: state_d = StSearch;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StSearch;
      phase_q     <= '0;
      ref_q       <= '0;
      delay_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ref_q       <= ref_d;
      delay_q     <= delay_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_locked    = (state_q == StLocked);
  assign o_delay     = delay_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker with a short search window (N_WIN=16, LOSS_THR=8).
// Sliced data lags the pushed reference so that the aligning delay is 5.
module tb_ber_checker;

  localparam int unsigned NWin = 16;
  localparam int unsigned Lag  = 6;  // data for symbol k is reference bit k-6 -> ref[5] pre-edge

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_valid;
  logic [7:0]  i_data;
  logic [1:0]  i_phase;
  logic        i_ref_valid;
  logic        i_ref_bit;
  logic        i_restart;
  logic        o_bit;
  logic        o_bit_valid;
  logic        o_locked;
  logic [8:0]  o_delay;
  logic [63:0] o_bit_count;
  logic [63:0] o_err_count;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  logic prbs_seq [511];

  ber_checker #(
    .N_WIN    (NWin),
    .LOSS_THR (8)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_phase     (i_phase),
    .i_ref_valid (i_ref_valid),
    .i_ref_bit   (i_ref_bit),
    .i_restart   (i_restart),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .o_locked    (o_locked),
    .o_delay     (o_delay),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int wrap511(input int x);
    return ((x % 511) + 511) % 511;
  endfunction

  // One symbol: decision + reference push in cycle 0, opposite-sign samples in cycles 1..3.
  task automatic run_sym(input logic inv, input logic chk_strobe, input logic restart);
    logic d;
    d           = prbs_seq[wrap511(k - Lag)] ^ inv;
    i_valid     = 1'b1;
    i_data      = d ? 8'h9C : 8'h64;
    i_ref_valid = 1'b1;
    i_ref_bit   = prbs_seq[wrap511(k)];
    i_restart   = restart;
    tick;
    if (chk_strobe) begin
      check_eq("strobe_on", o_bit_valid, 1);
      check_eq("sliced_bit", o_bit, d);
    end
    i_ref_valid = 1'b0;
    i_restart   = 1'b0;
    i_data      = d ? 8'h64 : 8'h9C;
    tick;
    if (chk_strobe) check_eq("strobe_off", o_bit_valid, 0);
    repeat (2) tick;
    k++;
  endtask

  initial begin
    logic [8:0] s;
    logic       b;
    logic       ever_locked;
    s = 9'h1FF;
    for (int i = 0; i < 511; i++) begin
      b           = s[8] ^ s[4];
      prbs_seq[i] = b;
      s           = {s[7:0], b};
    end

    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_data = '0; i_phase = 2'd0;
    i_ref_valid = 1'b0; i_ref_bit = 1'b0; i_restart = 1'b0;
    repeat (2) tick;
    check_eq("rst_locked", o_locked, 0);
    check_eq("rst_delay", o_delay, 0);
    check_eq("rst_bits", o_bit_count, 0);
    check_eq("rst_errs", o_err_count, 0);
    check_eq("rst_valid", o_bit_valid, 0);
    i_reset = 1'b0;

    // Search steps 0..5 then locks at delay 5 after 6 windows.
    for (int w = 0; w < 6; w++) begin
      for (int j = 0; j < NWin; j++) run_sym(1'b0, (w == 0 && j < 2), 1'b0);
      check_eq("srch_delay", o_delay, (w < 5) ? w + 1 : 5);
      check_eq("srch_locked", o_locked, (w < 5) ? 0 : 1);
    end
    check_eq("lock_bits", o_bit_count, 0);
    check_eq("lock_errs", o_err_count, 0);

    // Every 100th slice inverted over 800 bits.
    for (int i = 0; i < 800; i++) run_sym((i % 100) == 99, 1'b0, 1'b0);
    check_eq("ber_bits", o_bit_count, 800);
    check_eq("ber_errs", o_err_count, 8);
    check_eq("ber_locked", o_locked, 1);

    // Freeze for 50 cycles with activity on every input.
    i_enable = 1'b0;
    for (int c = 0; c < 50; c++) begin
      i_valid = c[0]; i_ref_valid = c[0]; i_ref_bit = ~c[1]; i_data = c[1] ? 8'h80 : 8'h01;
      i_restart = (c == 25);
      tick;
    end
    i_restart = 1'b0;
    check_eq("frz_bits", o_bit_count, 800);
    check_eq("frz_errs", o_err_count, 8);
    check_eq("frz_locked", o_locked, 1);
    check_eq("frz_delay", o_delay, 5);
    check_eq("frz_valid", o_bit_valid, 0);
    i_enable = 1'b1; i_valid = 1'b0; i_ref_valid = 1'b0;
    run_sym(1'b0, 1'b1, 1'b0);
    check_eq("resume_bits", o_bit_count, 801);
    for (int i = 0; i < 9; i++) run_sym(1'b0, 1'b0, 1'b0);
    check_eq("resume_bits10", o_bit_count, 810);
    check_eq("resume_errs", o_err_count, 8);

    // Finish current window cleanly, then a window with 10 errors.
    for (int i = 0; i < 6; i++) run_sym(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NWin; i++) run_sym(i < 10, 1'b0, 1'b0);
    check_eq("loss_bits", o_bit_count, 832);
    check_eq("loss_errs", o_err_count, 18);
`ifdef BER_LOCK_LOSS_EN
    check_eq("loss_locked", o_locked, 0);
    check_eq("loss_delay", o_delay, 0);
`else
    check_eq("loss_locked", o_locked, 1);
    check_eq("loss_delay", o_delay, 5);
`endif

    // Restart coinciding with a decision; that decision must not open the window.
    run_sym(1'b0, 1'b0, 1'b1);
    check_eq("rs_locked", o_locked, 0);
    check_eq("rs_delay", o_delay, 0);
    check_eq("rs_bits", o_bit_count, 0);
    check_eq("rs_errs", o_err_count, 0);
    for (int i = 0; i < 47; i++) run_sym(1'b0, 1'b0, 1'b0);
    check_eq("rs_delay47", o_delay, 2);
    run_sym(1'b0, 1'b0, 1'b0);
    check_eq("rs_delay48", o_delay, 3);

    // Asynchronous reset right after a decision, mid-window at delay 3.
    i_valid = 1'b1; i_data = 8'h80; i_ref_valid = 1'b1; i_ref_bit = 1'b1;
    tick;
    check_eq("pre_rst_valid", o_bit_valid, 1);
    #1 i_reset = 1'b1;
    #1;
    check_eq("arst_delay", o_delay, 0);
    check_eq("arst_valid", o_bit_valid, 0);
    check_eq("arst_bit", o_bit, 0);
    check_eq("arst_locked", o_locked, 0);
    i_valid = 1'b0; i_ref_valid = 1'b0;
    tick;
    i_reset = 1'b0;
    tick;
    check_eq("post_rst_delay", o_delay, 0);

    // Permanently inverted data: never locks, delay walks to 510 then wraps.
    ever_locked = 1'b0;
    for (int i = 0; i < 511 * NWin - 1; i++) begin
      run_sym(1'b1, 1'b0, 1'b0);
      if (i == NWin - 1) check_eq("inv_delay1", o_delay, 1);
      ever_locked = ever_locked | o_locked;
    end
    check_eq("inv_delay510", o_delay, 510);
    run_sym(1'b1, 1'b0, 1'b0);
    ever_locked = ever_locked | o_locked;
    check_eq("inv_wrap", o_delay, 0);
    check_eq("inv_never_locked", ever_locked, 0);
    check_eq("inv_bits", o_bit_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
